data_mem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder and its
// lane-alignment helper.
//   - Access size encodings as they arrive on req_size.
//   - FSM state encoding for the responder.
//   - The latched-request record type.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DMEM_WORD_BYTES = 4;

  // One captured core request, held for the duration of the wait states.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering for one word.
//   addr_lo  in   byte offset within the word (addr[1:0])
//   size     in   access size encoding
//   old_word in   current RAM word at the addressed index
//   wdata    in   right-aligned store data
//   wr_word  out  old_word with the addressed lanes replaced by store data
//   byte_en  out  lanes touched by the access (0 when misaligned/invalid)
//   rd_data  out  addressed lane(s) of old_word, zero-extended
//   misalign out  half at an odd address, or word not on a 4-byte boundary
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] wr_word,
  output logic [3:0]  byte_en,
  output logic [31:0] rd_data,
  output logic        misalign
);

  logic [31:0] shifted;

  assign misalign = ((size == SZ_HALF) && addr_lo[0]) ||
                    ((size == SZ_WORD) && (addr_lo != 2'b00));

  always_comb begin
    byte_en = 4'b0000;
    if (!misalign) begin
      case (size)
        SZ_BYTE: byte_en = 4'b0001 << addr_lo;
        SZ_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        SZ_WORD: byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

  // Each lane picks the store byte that lands on it: a byte store repeats
  // wdata[7:0] on every lane, a half store repeats wdata[15:0] on each
  // half, and byte_en selects which lanes are actually replaced.
  genvar gi;
  generate
    for (gi = 0; gi < DMEM_WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_src;
      always_comb begin
        case (size)
          SZ_BYTE: lane_src = wdata[7:0];
          SZ_HALF: lane_src = wdata[(gi % 2) * 8 +: 8];
          default: lane_src = wdata[gi * 8 +: 8];
        endcase
      end
      assign wr_word[gi * 8 +: 8] = byte_en[gi] ? lane_src : old_word[gi * 8 +: 8];
    end
  endgenerate

  // Aligned halves sit at offset 0 or 2, so one byte-granular shift serves
  // both byte and half extraction.
  assign shifted = old_word >> {addr_lo, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: rd_data = {24'h000000, shifted[7:0]};
      SZ_HALF: rd_data = {16'h0000, shifted[15:0]};
      SZ_WORD: rd_data = old_word;
      default: rd_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked, wait-stated word RAM serving the core's
// load/store port.
//   clk, rst    clock, asynchronous active-high reset
//   req_*       request channel (valid/ready, we, byte addr, size, wdata)
//   resp_*      response channel (valid/ready, zero-extended rdata, err)
// A request is captured in IDLE, waits WAIT_CYCLES edges (the capture edge
// counts as the first), is performed against the RAM, and the response is
// held in RESP until the core accepts it.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  dmem_req_t   req_reg;
  logic [31:0] mem [DEPTH_WORDS];

  dmem_req_t   acc;
  logic        accept;
  logic        do_access;
  logic [AW-1:0] word_idx;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] old_word;
  logic [31:0] wr_word;
  logic [3:0]  byte_en;
  logic [31:0] rd_data;
  logic        misalign;
  logic [31:0] rdata_next;

  assign req_ready  = (state_reg == ST_IDLE) & ~rst;
  assign resp_valid = (state_reg == ST_RESP);
  assign accept     = req_valid & req_ready;

  // With zero wait states the access happens on the capture edge, so the
  // live request fields are used; otherwise the latched copy is.
  always_comb begin
    if (state_reg == ST_IDLE)
      acc = '{we: req_we, addr: req_addr, size: req_size, wdata: req_wdata};
    else
      acc = req_reg;
  end

  assign do_access = ((state_reg == ST_WAIT) && (cnt_reg == 4'd1)) ||
                     (accept && (WAIT_CYCLES == 0));

  // High address bits only feed the range check; the index never wraps.
  assign word_idx     = acc.addr[AW+1:2];
  assign out_of_range = (acc.addr[31:2] >= 30'(DEPTH_WORDS));
  assign old_word     = mem[word_idx];
  assign acc_err      = (acc.size == SZ_INV) | misalign | out_of_range;
  assign rdata_next   = (acc_err || acc.we) ? 32'h0000_0000 : rd_data;

  dmem_lane_align u_align (
    .addr_lo  (acc.addr[1:0]),
    .size     (acc.size),
    .old_word (old_word),
    .wdata    (acc.wdata),
    .wr_word  (wr_word),
    .byte_en  (byte_en),
    .rd_data  (rd_data),
    .misalign (misalign)
  );

  // RAM contents survive reset. A store still waiting is dropped because
  // reset returns the FSM to IDLE before its access edge arrives.
  always_ff @(posedge clk) begin
    if (do_access && acc.we && !acc_err && (byte_en != 4'b0000))
      mem[word_idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      req_reg    <= '0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_reg <= acc;
            if (WAIT_CYCLES == 0) begin
              state_reg  <= ST_RESP;
              resp_rdata <= rdata_next;
              resp_err   <= acc_err;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg  <= ST_RESP;
            resp_rdata <= rdata_next;
            resp_err   <= acc_err;
          end
        end
        ST_RESP: begin
          if (resp_ready)
            state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a response scoreboard.
// The driver pushes the hand-computed response of every request it issues;
// a monitor pops and compares whenever a response handshake completes.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%09h", name, act);
    end
  endtask

  // Monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {resp_err, resp_rdata}, 33'h1_FFFF_FFFF);
      end else begin
        check("resp", {resp_err, resp_rdata}, exp_q.pop_front());
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 ns after the
  // accepting edge.
  task automatic send(input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_size = sz; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 33'd0, 33'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    exp_q.push_back({ee, er});
    send(we, a, sz, wd);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 33'(exp_q.size()), 33'd0);
      exp_q.delete();
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    issue(we, a, sz, wd, er, ee);
    wait_resp();
  endtask

  initial begin
    int n;
    // Reset state
    #1;
    check("rst_req_ready",  {32'd0, req_ready},  33'd0);
    check("rst_resp_valid", {32'd0, resp_valid}, 33'd0);
    check("rst_resp",       {resp_err, resp_rdata}, 33'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("idle_req_ready", {32'd0, req_ready}, 33'd1);

    // 1: word store/load and latency (capture edge counts as edge 1)
    txn(1'b1, 32'h10, SZ_WORD, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 32'h10, SZ_WORD, 32'h0, 32'hDEADBEEF, 1'b0);
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("load_latency_edges", 33'(n), 33'(WAITC + 1));
    wait_resp();

    // 2: byte/half lane steering
    txn(1'b1, 32'h10, SZ_WORD, 32'h0,        32'h0,        1'b0);
    txn(1'b1, 32'h11, SZ_BYTE, 32'h55AA,     32'h0,        1'b0);
    txn(1'b0, 32'h10, SZ_WORD, 32'h0,        32'h0000AA00, 1'b0);
    txn(1'b0, 32'h11, SZ_BYTE, 32'h0,        32'h000000AA, 1'b0);
    txn(1'b0, 32'h10, SZ_HALF, 32'h0,        32'h0000AA00, 1'b0);
    txn(1'b1, 32'h12, SZ_HALF, 32'hFFFF1234, 32'h0,        1'b0);
    txn(1'b0, 32'h12, SZ_HALF, 32'h0,        32'h00001234, 1'b0);
    txn(1'b0, 32'h10, SZ_WORD, 32'h0,        32'h1234AA00, 1'b0);

    // 3: misaligned and invalid-size requests
    txn(1'b0, 32'h12, SZ_WORD, 32'h0,        32'h0, 1'b1);
    txn(1'b0, 32'h13, SZ_HALF, 32'h0,        32'h0, 1'b1);
    txn(1'b0, 32'h10, SZ_INV,  32'h0,        32'h0, 1'b1);
    txn(1'b1, 32'h12, SZ_WORD, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn(1'b0, 32'h10, SZ_WORD, 32'h0,        32'h1234AA00, 1'b0);

    // 4: range boundary, including high address bits
    txn(1'b0, 32'h400,      SZ_WORD, 32'h0,        32'h0,        1'b1);
    txn(1'b1, 32'h400,      SZ_WORD, 32'h11111111, 32'h0,        1'b1);
    txn(1'b1, 32'h80000010, SZ_WORD, 32'h22222222, 32'h0,        1'b1);
    txn(1'b1, 32'h3FC,      SZ_WORD, 32'hCAFEF00D, 32'h0,        1'b0);
    txn(1'b0, 32'h3FC,      SZ_WORD, 32'h0,        32'hCAFEF00D, 1'b0);
    txn(1'b0, 32'h10,       SZ_WORD, 32'h0,        32'h1234AA00, 1'b0);

    // 5: response back-pressure, then back-to-back request
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, SZ_WORD, 32'h0, 32'h1234AA00, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid",     {32'd0, resp_valid}, 33'd1);
      check("hold_resp",      {resp_err, resp_rdata}, 33'h0_1234AA00);
      check("hold_req_ready", {32'd0, req_ready}, 33'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h000000AA});
    req_we = 1'b0; req_addr = 32'h11; req_size = SZ_BYTE; req_wdata = 32'h0; req_valid = 1'b1;
    @(negedge clk);
    check("resp_still_busy", {32'd0, req_ready}, 33'd0);
    @(negedge clk);
    check("idle_after_ack", {31'd0, resp_valid, req_ready}, 33'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_accepted", {32'd0, req_ready}, 33'd0);
    wait_resp();

    // 6: reset during the wait states of a store
    txn(1'b1, 32'h20, SZ_WORD, 32'h0, 32'h0, 1'b0);
    send(1'b1, 32'h20, SZ_WORD, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid",     {32'd0, resp_valid}, 33'd0);
    check("midrst_resp",      {resp_err, resp_rdata}, 33'd0);
    check("midrst_req_ready", {32'd0, req_ready}, 33'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_req_ready", {32'd0, req_ready}, 33'd0);
    @(negedge clk) rst = 1'b0;
    txn(1'b0, 32'h20, SZ_WORD, 32'h0, 32'h00000000, 1'b0);
    txn(1'b0, 32'h3FC, SZ_WORD, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
